// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: execute-stage issue/stall/writeback control for the iterative multdiv unit.
// Ports: clock/reset, op_* capture, flush, wb_ready, ctrl_* start pulses, operands, multdiv result, stall, wb_*.
module multdiv_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int RSTATUS_REG    = 30,
   parameter int MULT_EXC_CODE  = 4,
   parameter int DIV_EXC_CODE   = 5,
   parameter int TIMEOUT_CODE   = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        op_is_div,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  op_rd,
   input  logic        flush,
   input  logic        wb_ready,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] data_operandA,
   output logic [31:0] data_operandB,
   input  logic [31:0] data_result,
   input  logic        data_exception,
   input  logic        data_resultRDY,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_BUSY,
      S_WB
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          w_cap;
   logic          w_load;
   logic          w_tmo;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [4:0]    r_rd;
   logic          r_is_div;
   logic [4:0]    r_wb_rd;
   logic [31:0]   r_wb_data;
   logic [31:0]   w_exc_code;

   always_comb begin
      w_next = r_state;
      w_cap  = 1'b0;
      w_load = 1'b0;
      w_tmo  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (op_valid && !flush) begin
               w_next = S_ISSUE;
               w_cap  = 1'b1;
            end
         end
         S_ISSUE: begin
            w_next = flush ? S_IDLE : S_BUSY;
         end
         S_BUSY: begin
            // r_cnt == 0 marks the first BUSY cycle, where ready may be stale
            if (flush) begin
               w_next = S_IDLE;
            end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               w_next = S_WB;
               w_load = 1'b1;
               w_tmo  = 1'b1;
            end else if (data_resultRDY && (r_cnt != '0)) begin
               w_next = S_WB;
               w_load = 1'b1;
            end
         end
         S_WB: begin
            if (flush || wb_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_rd     <= '0;
         r_is_div <= 1'b0;
      end else if (w_cap) begin
         r_a      <= op_a;
         r_b      <= op_b;
         r_rd     <= op_rd;
         r_is_div <= op_is_div;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_cnt <= '0;
      end else if ((r_state == S_BUSY) && (r_cnt != CW'(TIMEOUT_CYCLES))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_exc_code = r_is_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else if (w_load) begin
         if (w_tmo) begin
            r_wb_rd   <= 5'(RSTATUS_REG);
            r_wb_data <= 32'(TIMEOUT_CODE);
         end else if (data_exception) begin
            r_wb_rd   <= 5'(RSTATUS_REG);
            r_wb_data <= w_exc_code;
         end else begin
            r_wb_rd   <= r_rd;
            r_wb_data <= data_result;
         end
      end
   end

   assign ctrl_MULT     = (r_state == S_ISSUE) && !r_is_div;
   assign ctrl_DIV      = (r_state == S_ISSUE) && r_is_div;
   assign data_operandA = r_a;
   assign data_operandB = r_b;
   assign wb_valid      = (r_state == S_WB);
   assign wb_rd         = r_wb_rd;
   assign wb_data       = r_wb_data;

   // a flush always releases the pipeline in the cycle it is seen
   assign stall = !flush &&
                  (((r_state == S_IDLE) && op_valid) ||
                   (r_state == S_ISSUE) ||
                   (r_state == S_BUSY) ||
                   ((r_state == S_WB) && !wb_ready));

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: directed vector bench for multdiv_issue_ctrl.
// Drives multdiv responses by hand and checks pulses, stall and writeback.
module tb_multdiv_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_is_div = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  op_rd = '0;
   logic        flush = 1'b0;
   logic        wb_ready = 1'b0;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result = '0;
   logic        data_exception = 1'b0;
   logic        data_resultRDY = 1'b0;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int total = 0;
   int bad = 0;

   multdiv_issue_ctrl dut (
      .clock(clock),
      .reset(reset),
      .op_valid(op_valid),
      .op_is_div(op_is_div),
      .op_a(op_a),
      .op_b(op_b),
      .op_rd(op_rd),
      .flush(flush),
      .wb_ready(wb_ready),
      .ctrl_MULT(ctrl_MULT),
      .ctrl_DIV(ctrl_DIV),
      .data_operandA(data_operandA),
      .data_operandB(data_operandB),
      .data_result(data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
      .stall(stall),
      .wb_valid(wb_valid),
      .wb_rd(wb_rd),
      .wb_data(wb_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        exc;
      int          lat;
      int          hold;
      logic        stale;
      logic        tmo;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_op(input vec_t v);
      @(posedge clock); #1;
      op_valid  = 1'b1;
      op_is_div = v.is_div;
      op_a      = v.a;
      op_b      = v.b;
      op_rd     = v.rd;
      @(negedge clock);
      chk("cap_stall", 32'(stall), 32'd1);
      @(posedge clock); #1;
      op_valid = 1'b0;
      op_a     = 32'h1234_5678;
      op_b     = 32'h8765_4321;
      @(negedge clock);
      chk("iss_mult", 32'(ctrl_MULT), 32'(!v.is_div));
      chk("iss_div", 32'(ctrl_DIV), 32'(v.is_div));
      chk("iss_opa", data_operandA, v.a);
      chk("iss_opb", data_operandB, v.b);
      chk("iss_stall", 32'(stall), 32'd1);
      for (int i = 1; i <= v.lat; i++) begin
         @(posedge clock); #1;
         data_resultRDY = !v.tmo && ((i == v.lat) || ((i == 1) && v.stale));
         data_result    = (i == v.lat) ? v.res : 32'hDEAD_BEEF;
         data_exception = (i == v.lat) ? v.exc : 1'b1;
         @(negedge clock);
         chk("busy_pulse", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
         chk("busy_stall", 32'(stall), 32'd1);
         chk("busy_wbv", 32'(wb_valid), 32'd0);
      end
      for (int h = 0; h <= v.hold; h++) begin
         @(posedge clock); #1;
         data_resultRDY = 1'b0;
         data_exception = 1'b0;
         data_result    = 32'h0BAD_0BAD;
         wb_ready       = (h == v.hold);
         @(negedge clock);
         chk("wb_valid", 32'(wb_valid), 32'd1);
         chk("wb_rd", 32'(wb_rd), 32'(v.exp_rd));
         chk("wb_data", wb_data, v.exp_data);
         chk("wb_stall", 32'(stall), 32'(h != v.hold));
      end
      @(posedge clock); #1;
      wb_ready = 1'b0;
      @(negedge clock);
      chk("post_wbv", 32'(wb_valid), 32'd0);
      chk("post_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      //        div   a             b             rd  res           exc  lat hold stale tmo  exp_rd exp_data
      vecs[0] = '{1'b0, 32'd7,        32'hFFFF_FFFA, 5'd5, 32'hFFFF_FFD6, 1'b0, 4,  0, 1'b0, 1'b0, 5'd5,  32'hFFFF_FFD6};
      vecs[1] = '{1'b1, 32'd100,      32'hFFFF_FFF9, 5'd9, 32'hFFFF_FFF2, 1'b0, 6,  0, 1'b0, 1'b0, 5'd9,  32'hFFFF_FFF2};
      vecs[2] = '{1'b1, 32'd5,        32'd0,         5'd4, 32'h0000_0000, 1'b1, 3,  0, 1'b0, 1'b0, 5'd30, 32'd5};
      vecs[3] = '{1'b0, 32'h4000_0000, 32'd4,        5'd8, 32'h0000_0000, 1'b1, 5,  0, 1'b0, 1'b0, 5'd30, 32'd4};
      vecs[4] = '{1'b0, 32'd2,        32'd2,         5'd0, 32'd4,         1'b0, 2,  3, 1'b0, 1'b0, 5'd0,  32'd4};
      vecs[5] = '{1'b0, 32'd11,       32'd13,        5'd12, 32'd0,        1'b0, 40, 0, 1'b0, 1'b1, 5'd30, 32'd6};
      vecs[6] = '{1'b0, 32'd3,        32'd3,         5'd17, 32'd9,        1'b0, 3,  0, 1'b1, 1'b0, 5'd17, 32'd9};

      #3;
      chk("rst_pulse", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wbv", 32'(wb_valid), 32'd0);
      chk("rst_wbrd", 32'(wb_rd), 32'd0);
      chk("rst_wbdata", wb_data, 32'd0);
      chk("rst_opa", data_operandA, 32'd0);
      #9;
      reset = 1'b1;

      for (int k = 0; k < 6; k++) begin
         run_op(vecs[k]);
      end

      // flush in IDLE blocks capture
      @(posedge clock); #1;
      op_valid = 1'b1;
      flush    = 1'b1;
      op_a     = 32'd77;
      @(negedge clock);
      chk("iflush_stall", 32'(stall), 32'd0);
      @(posedge clock); #1;
      op_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clock);
      chk("iflush_pulse", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
      chk("iflush_opa", data_operandA, 32'd11);

      // flush in BUSY cycle 3 with a simultaneous ready
      @(posedge clock); #1;
      op_valid = 1'b1;
      op_a     = 32'd11;
      op_b     = 32'd12;
      op_rd    = 5'd7;
      @(posedge clock); #1;
      op_valid = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      flush          = 1'b1;
      data_resultRDY = 1'b1;
      data_result    = 32'd132;
      @(negedge clock);
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_wbv", 32'(wb_valid), 32'd0);
      @(posedge clock); #1;
      flush = 1'b0;
      @(negedge clock);
      chk("flush_nowb", 32'(wb_valid), 32'd0);
      chk("flush_idle", 32'(stall), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("flush_nowb2", 32'(wb_valid), 32'd0);

      // stale ready held into the first BUSY cycle of the next op
      run_op(vecs[6]);

      // async reset mid-BUSY
      @(posedge clock); #1;
      op_valid = 1'b1;
      op_a     = 32'd7;
      op_b     = 32'd8;
      op_rd    = 5'd3;
      @(posedge clock); #1;
      op_valid = 1'b0;
      repeat (2) begin
         @(posedge clock); #1;
      end
      chk("pre_rst_stall", 32'(stall), 32'd1);
      reset = 1'b0;
      #1;
      chk("arst_pulse", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
      chk("arst_opa", data_operandA, 32'd0);
      chk("arst_opb", data_operandB, 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_wbv", 32'(wb_valid), 32'd0);
      chk("arst_wbrd", 32'(wb_rd), 32'd0);
      chk("arst_wbdata", wb_data, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      run_op(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
